// File: rtl/rx_iq_intf.sv
// RX I/Q interface: signed gain with saturation, then a first-word-fall-through FIFO to the rx core.
// Optional DC-removal front stage when RX_IQ_DC_REMOVE_EN is defined (adds one cycle of latency).
module rx_iq_intf #(
    parameter int IQ_DATA_WIDTH   = 16,
    parameter int GAIN_WIDTH      = 10,
    parameter int GAIN_FRAC       = 7,
    parameter int FIFO_ADDR_WIDTH = 9,
    parameter int DC_SHIFT        = 10
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [2*IQ_DATA_WIDTH-1:0]   adc_iq_pack,
    input  logic                         adc_iq_valid,
    input  logic [GAIN_WIDTH-1:0]        rx_gain,
    input  logic [FIFO_ADDR_WIDTH:0]     rx_hold_threshold,
    input  logic                         overflow_count_clr,
    output logic [IQ_DATA_WIDTH-1:0]     rx_i,
    output logic [IQ_DATA_WIDTH-1:0]     rx_q,
    output logic                         rx_iq_valid,
    input  logic                         rx_iq_ready,
    output logic                         rx_iq_fifo_empty,
    output logic                         rx_iq_fifo_full,
    output logic                         rx_almost_full,
    output logic [FIFO_ADDR_WIDTH:0]     data_count,
    output logic [15:0]                  overflow_count
);
    localparam int IQW   = IQ_DATA_WIDTH;
    localparam int GW    = GAIN_WIDTH;
    localparam int AW    = FIFO_ADDR_WIDTH;
    localparam int PW    = IQW + GW;
    localparam int DEPTH = 1 << AW;
    localparam logic signed [63:0] SMAX = (64'sd1 <<< (IQW - 1)) - 64'sd1;
    localparam logic signed [63:0] SMIN = -(64'sd1 <<< (IQW - 1));

    function automatic logic [IQW-1:0] sat_iq(input logic signed [63:0] v);
        if (v > SMAX)      return SMAX[IQW-1:0];
        else if (v < SMIN) return SMIN[IQW-1:0];
        else               return v[IQW-1:0];
    endfunction

    // Component 0 is I, component 1 is Q.
    logic [1:0][IQW-1:0] x_in;
    logic [1:0][IQW-1:0] s1_x;
    logic                s1_v;

    assign x_in = adc_iq_pack;

`ifdef RX_IQ_DC_REMOVE_EN
    localparam int ACW = IQW + DC_SHIFT + 1;

    logic [1:0][ACW-1:0] acc_q, acc_d;
    logic [1:0][IQW-1:0] dc_y_q, dc_y_d;
    logic                v0_q;

    for (genvar c = 0; c < 2; c++) begin : g_dc
        logic signed [ACW-1:0] xe;
        logic signed [ACW-1:0] est;
        assign xe        = ACW'($signed(x_in[c]));
        assign est       = $signed(acc_q[c]) >>> DC_SHIFT;
        // Output uses the estimate from before this sample's update.
        assign acc_d[c]  = xe + $signed(acc_q[c]) - est;
        assign dc_y_d[c] = sat_iq(64'(xe - est));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q  <= '0;
            dc_y_q <= '0;
            v0_q   <= 1'b0;
        end else begin
            v0_q <= adc_iq_valid;
            if (adc_iq_valid) begin
                acc_q  <= acc_d;
                dc_y_q <= dc_y_d;
            end
        end
    end

    assign s1_x = dc_y_q;
    assign s1_v = v0_q;
`else
    assign s1_x = x_in;
    assign s1_v = adc_iq_valid;
`endif

    logic [1:0][PW-1:0]  p_q, p_d;
    logic [1:0][IQW-1:0] s_q, s_d;
    logic                v1_q, v2_q;

    for (genvar c = 0; c < 2; c++) begin : g_gain
        logic signed [PW-1:0] sh;
        // Operands extended to the full product width so the multiply is exact.
        assign p_d[c] = $signed(PW'($signed(s1_x[c]))) * $signed(PW'($signed(rx_gain)));
        assign sh     = $signed(p_q[c]) >>> GAIN_FRAC;
        assign s_d[c] = sat_iq(64'(sh));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            p_q  <= '0;
            s_q  <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            p_q  <= p_d;
            v1_q <= s1_v;
            s_q  <= s_d;
            v2_q <= v1_q;
        end
    end

    logic [1:0][IQW-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         cnt_q, cnt_d;
    logic [15:0]         ovf_q, ovf_d;
    logic                empty, full, wr_en, pop, ovf;
    logic [1:0][IQW-1:0] head;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    // Full check is on pre-pop occupancy: a same-cycle pop does not make room.
    assign wr_en = v2_q && !full;
    assign ovf   = v2_q && full;
    assign pop   = !empty && rx_iq_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        ovf_d    = ovf_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        if (overflow_count_clr)          ovf_d = '0;
        else if (ovf && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= s_q;
    end

    assign head             = mem[rd_ptr_q];
    assign rx_i             = empty ? '0 : head[0];
    assign rx_q             = empty ? '0 : head[1];
    assign rx_iq_valid      = !empty;
    assign rx_iq_fifo_empty = empty;
    assign rx_iq_fifo_full  = full;
    assign rx_almost_full   = (cnt_q > rx_hold_threshold);
    assign data_count       = cnt_q;
    assign overflow_count   = ovf_q;

endmodule

// File: tb/tb_rx_iq_intf.sv
// Bench for rx_iq_intf: table of single-sample gain/saturation vectors plus scoreboarded streams
// for fill/overflow, steady-state throughput, overflow clear, reset mid-stream and DC removal.
module tb_rx_iq_intf;
    localparam int IQW   = 16;
    localparam int GW    = 10;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
`ifdef RX_IQ_DC_REMOVE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [2*IQW-1:0] adc_iq_pack = '0;
    logic            adc_iq_valid = 1'b0;
    logic [GW-1:0]   rx_gain = '0;
    logic [AW:0]     rx_hold_threshold = '0;
    logic            overflow_count_clr = 1'b0;
    logic [IQW-1:0]  rx_i, rx_q;
    logic            rx_iq_valid;
    logic            rx_iq_ready = 1'b0;
    logic            rx_iq_fifo_empty, rx_iq_fifo_full, rx_almost_full;
    logic [AW:0]     data_count;
    logic [15:0]     overflow_count;

    rx_iq_intf dut (
        .clk(clk), .rstn(rstn), .adc_iq_pack(adc_iq_pack), .adc_iq_valid(adc_iq_valid),
        .rx_gain(rx_gain), .rx_hold_threshold(rx_hold_threshold),
        .overflow_count_clr(overflow_count_clr), .rx_i(rx_i), .rx_q(rx_q),
        .rx_iq_valid(rx_iq_valid), .rx_iq_ready(rx_iq_ready),
        .rx_iq_fifo_empty(rx_iq_fifo_empty), .rx_iq_fifo_full(rx_iq_fifo_full),
        .rx_almost_full(rx_almost_full), .data_count(data_count),
        .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    typedef struct { int ei; int eq; } exp_t;
    typedef struct { int g; int xi; int xq; int ei; int eq; } vec_t;

    exp_t   sbq[$];
    longint acc_m[2];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     sb_on   = 1'b0;
    bit     sb_push = 1'b0;
    int     last_i  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int xi, input int xq);
        int     xs[2];
        int     e[2];
        longint y;
        int     g;
        xs[0] = xi;
        xs[1] = xq;
        g = $signed(rx_gain);
        adc_iq_pack  = {16'(xq), 16'(xi)};
        adc_iq_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
`ifdef RX_IQ_DC_REMOVE_EN
            longint est;
            est = acc_m[c] >>> 10;
            y = sat(xs[c] - est);
            acc_m[c] = acc_m[c] + xs[c] - est;
`else
            y = xs[c];
`endif
            e[c] = int'(sat((y * g) >>> 7));
        end
        if (sb_push) sbq.push_back('{e[0], e[1]});
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        adc_iq_valid = 1'b0;
        overflow_count_clr = 1'b0;
        tick();
        rstn = 1'b1;
        sbq.delete();
        acc_m[0] = 0;
        acc_m[1] = 0;
    endtask

    task automatic wait_empty(input int budget);
        int k = 0;
        while (!rx_iq_fifo_empty && k < budget) begin
            tick();
            k++;
        end
        check("drain_timeout_empty", rx_iq_fifo_empty, 1);
    endtask

    // Scoreboard: every accepted head sample is checked against the oldest expected entry.
    always @(negedge clk) begin
        if (sb_on && rstn && rx_iq_valid && rx_iq_ready) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: popped i=%0d q=%0d with nothing expected",
                         $signed(rx_i), $signed(rx_q));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_i", $signed(rx_i), e.ei);
                check("sb_q", $signed(rx_q), e.eq);
                last_i = $signed(rx_i);
            end
        end
    end

    initial begin
        vec_t tbl[6];
        int   af_cnt, full_cnt, bad, val, k;

        tbl[0] = '{128,   1000,  -1000,   1000,  -1000};
        tbl[1] = '{511,  32767, -32768,  32767, -32768};
        tbl[2] = '{511, -32768,      0, -32768,      0};
        tbl[3] = '{-512, -32768, 32767,  32767, -32768};
        tbl[4] = '{64,      -3,      3,     -2,      1};
        tbl[5] = '{-512,     1,    100,     -4,   -400};

        tick();
        do_reset();
        check("rst_empty", rx_iq_fifo_empty, 1);
        check("rst_valid", rx_iq_valid, 0);
        check("rst_full", rx_iq_fifo_full, 0);
        check("rst_afull", rx_almost_full, 0);
        check("rst_count", data_count, 0);
        check("rst_ovf", overflow_count, 0);
        check("rst_i", rx_i, 0);
        check("rst_q", rx_q, 0);

        // Single isolated samples straight after reset (DC estimate is still zero).
        for (int n = 0; n < 6; n++) begin
            do_reset();
            rx_gain = 10'(tbl[n].g);
            rx_iq_ready = 1'b0;
            drive(tbl[n].xi, tbl[n].xq);
            tick();
            adc_iq_valid = 1'b0;
            repeat (LAT) tick();
            check($sformatf("vec%0d_valid", n), rx_iq_valid, 1);
            check($sformatf("vec%0d_count", n), data_count, 1);
            check($sformatf("vec%0d_i", n), $signed(rx_i), tbl[n].ei);
            check($sformatf("vec%0d_q", n), $signed(rx_q), tbl[n].eq);
            rx_iq_ready = 1'b1;
            tick();
            rx_iq_ready = 1'b0;
            check($sformatf("vec%0d_empty", n), rx_iq_fifo_empty, 1);
            check($sformatf("vec%0d_i0", n), rx_i, 0);
        end

        // Fill with 520 samples, no consumer: threshold crossing, full, 8 drops.
        do_reset();
        rx_gain = 10'd200;
        rx_hold_threshold = 10'd400;
        rx_iq_ready = 1'b0;
        sb_push = 1'b1;
        af_cnt = -1;
        full_cnt = -1;
        for (int n = 0; n < 520; n++) begin
            drive(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
            tick();
            if (af_cnt < 0 && rx_almost_full) af_cnt = int'(data_count);
            if (full_cnt < 0 && rx_iq_fifo_full) full_cnt = int'(data_count);
        end
        adc_iq_valid = 1'b0;
        repeat (LAT + 1) tick();
        check("fill_afull_at", af_cnt, 401);
        check("fill_full_at", full_cnt, 512);
        check("fill_count", data_count, 512);
        check("fill_full", rx_iq_fifo_full, 1);
        check("fill_ovf", overflow_count, 8);
        repeat (8) void'(sbq.pop_back());
        sb_on = 1'b1;
        rx_iq_ready = 1'b1;
        wait_empty(600);
        rx_iq_ready = 1'b0;
        check("fill_sb_left", sbq.size(), 0);

        // Ramp with the consumer keeping pace once occupancy reaches 100.
        do_reset();
        rx_gain = 10'd128;
        rx_iq_ready = 1'b0;
        val = 0;
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            drive(val, -val);
            val++;
            if (!rx_iq_ready && data_count == 100) rx_iq_ready = 1'b1;
            tick();
            if (rx_iq_ready && data_count != 100) bad++;
        end
        adc_iq_valid = 1'b0;
        check("ramp_ready_set", rx_iq_ready, 1);
        check("ramp_hold_100_bad", bad, 0);
        wait_empty(300);
        check("ramp_sb_left", sbq.size(), 0);
        sb_on = 1'b0;
        sb_push = 1'b0;

        // Overflow clear coinciding with an overflow increment.
        do_reset();
        rx_iq_ready = 1'b0;
        for (int n = 0; n < DEPTH + LAT + 5; n++) begin
            drive(n % 1000, 0);
            tick();
        end
        check("ovf_before_clr", overflow_count, 5);
        overflow_count_clr = 1'b1;
        drive(1, 1);
        tick();
        overflow_count_clr = 1'b0;
        check("ovf_clr_wins", overflow_count, 0);
        drive(2, 2);
        tick();
        check("ovf_resume", overflow_count, 1);

        // Reset mid-stream with samples in flight.
        do_reset();
        rx_iq_ready = 1'b0;
        k = 0;
        while (data_count != 100 && k < 300) begin
            drive(k, k);
            tick();
            k++;
        end
        check("mid_count100", data_count, 100);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        adc_iq_valid = 1'b0;
        sbq.delete();
        acc_m[0] = 0;
        acc_m[1] = 0;
        check("mid_rst_empty", rx_iq_fifo_empty, 1);
        check("mid_rst_valid", rx_iq_valid, 0);
        check("mid_rst_count", data_count, 0);
        check("mid_rst_ovf", overflow_count, 0);
        check("mid_rst_i", rx_i, 0);
        repeat (LAT + 3) tick();
        check("mid_no_inflight", data_count, 0);

        // Long constant input: DC removal drives it to ~0, otherwise it passes unchanged.
        do_reset();
        rx_gain = 10'd128;
        rx_iq_ready = 1'b1;
        sb_on = 1'b1;
        sb_push = 1'b1;
        for (int n = 0; n < 20000; n++) begin
            drive(500, -300);
            tick();
        end
        adc_iq_valid = 1'b0;
        wait_empty(50);
        check("dc_sb_left", sbq.size(), 0);
`ifdef RX_IQ_DC_REMOVE_EN
        check("dc_final_small", (last_i <= 2 && last_i >= -2) ? 1 : 0, 1);
`else
        check("dc_final_passthru", last_i, 500);
`endif
        sb_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
